// File: rtl/regfile_debug_port.sv
// ---------------------------------------------------------------------------
// regfile_debug_port
//
// Debug-side initiator for the 32 x XLEN register file. Accepts host commands
// on a valid/ready channel and drives the register file's two read ports and
// single write port on the host's behalf. Reads are bursts that fetch two
// consecutive registers per access and stream them back one word at a time
// over a valid/ready response channel. Writes are single-register transfers.
// `busy` is asserted whenever the block owns the register file ports.
//
// Ports:
//   clock, resetn                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_write                     1 = single write, 0 = burst read
//   cmd_addr, cmd_count           start register, read burst length
//   cmd_wdata                     write data
//   rf_read1 / rf_read2           register file read addresses
//   rf_data1 / rf_data2           register file read data (combinational)
//   rf_write_reg/_data/rf_reg_write  register file write port
//   rsp_valid / rsp_ready         response handshake
//   rsp_data, rsp_addr, rsp_last  response word, its register number, last flag
//   busy                          high whenever not IDLE
// ---------------------------------------------------------------------------
module regfile_debug_port #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RAW  = 6
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [4:0]      cmd_addr,
    input  logic [5:0]      cmd_count,
    input  logic [XLEN-1:0] cmd_wdata,
    output logic [RAW-1:0]  rf_read1,
    output logic [RAW-1:0]  rf_read2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    output logic [RAW-1:0]  rf_write_reg,
    output logic [XLEN-1:0] rf_write_data,
    output logic            rf_reg_write,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [4:0]      rsp_addr,
    output logic            rsp_last,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        FETCH = 3'd2,
        SEND0 = 3'd3,
        SEND1 = 3'd4
    } state_t;

    state_t            state_q,     state_d;
    logic [4:0]        addr_q,      addr_d;
    logic [XLEN-1:0]   wdata_q,     wdata_d;
    logic [5:0]        remaining_q, remaining_d;
    logic [XLEN-1:0]   buf0_q,      buf0_d;
    logic [XLEN-1:0]   buf1_q,      buf1_d;

    // Second register of the current pair; 5-bit sum wraps 31 -> 0.
    logic [4:0]        addr_plus1;
    assign addr_plus1 = addr_q + 5'd1;

    // Burst lengths beyond the register file size are clamped to it.
    function automatic logic [5:0] sat_count(input logic [5:0] cnt);
        if (cnt > 6'(NREG)) begin
            return 6'(NREG);
        end
        return cnt;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        remaining_d = remaining_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    remaining_d = sat_count(cmd_count);
                    if (cmd_write) begin
                        state_d = WRITE;
                    end else if (sat_count(cmd_count) != 6'd0) begin
                        state_d = FETCH;
                    end
                end
            end

            WRITE: begin
                state_d = IDLE;
            end

            // Snapshot both registers; later core writes are not reflected.
            FETCH: begin
                buf0_d  = rf_data1;
                buf1_d  = rf_data2;
                state_d = SEND0;
            end

            SEND0: begin
                if (rsp_ready) begin
                    state_d = (remaining_q == 6'd1) ? IDLE : SEND1;
                end
            end

            SEND1: begin
                if (rsp_ready) begin
                    // Guarded so the counter can never wrap below zero.
                    remaining_d = (remaining_q >= 6'd2) ? remaining_q - 6'd2 : 6'd0;
                    addr_d      = addr_q + 5'd2;
                    state_d     = (remaining_q <= 6'd2) ? IDLE : FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

    // Outputs are pure decodes of registered state, so reset clears them
    // asynchronously and nothing depends combinationally on cmd_valid.
    always_comb begin
        cmd_ready     = (state_q == IDLE);
        busy          = (state_q != IDLE);
        rf_read1      = '0;
        rf_read2      = '0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        rf_reg_write  = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_addr      = '0;
        rsp_last      = 1'b0;

        case (state_q)
            WRITE: begin
                rf_write_reg  = RAW'(addr_q);
                rf_write_data = wdata_q;
                // x0 is hardwired zero, so never strobe a write to it.
                rf_reg_write  = (addr_q != 5'd0);
            end
            FETCH: begin
                rf_read1 = RAW'(addr_q);
                rf_read2 = RAW'(addr_plus1);
            end
            SEND0: begin
                rsp_valid = 1'b1;
                rsp_data  = buf0_q;
                rsp_addr  = addr_q;
                rsp_last  = (remaining_q == 6'd1);
            end
            SEND1: begin
                rsp_valid = 1'b1;
                rsp_data  = buf1_q;
                rsp_addr  = addr_plus1;
                rsp_last  = (remaining_q == 6'd2);
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
// ---------------------------------------------------------------------------
// tb_regfile_debug_port
//
// Bench for regfile_debug_port. Holds a behavioural register file, issues
// write and burst-read commands with randomized data and response
// backpressure, and compares every response against the list of words the
// burst should return (register number, snapshot value, last flag).
// ---------------------------------------------------------------------------
module tb_regfile_debug_port;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int RAW  = 6;

    logic            clock;
    logic            resetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [4:0]      cmd_addr;
    logic [5:0]      cmd_count;
    logic [XLEN-1:0] cmd_wdata;
    logic [RAW-1:0]  rf_read1;
    logic [RAW-1:0]  rf_read2;
    logic [XLEN-1:0] rf_data1;
    logic [XLEN-1:0] rf_data2;
    logic [RAW-1:0]  rf_write_reg;
    logic [XLEN-1:0] rf_write_data;
    logic            rf_reg_write;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_addr;
    logic            rsp_last;
    logic            busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural register file.
    logic [XLEN-1:0] regs [NREG];

    assign rf_data1 = regs[rf_read1[4:0]];
    assign rf_data2 = regs[rf_read2[4:0]];

    always @(posedge clock) begin
        if (rf_reg_write && rf_write_reg[4:0] != 5'd0) begin
            regs[rf_write_reg[4:0]] <= rf_write_data;
        end
    end

    regfile_debug_port #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_count     (cmd_count),
        .cmd_wdata     (cmd_wdata),
        .rf_read1      (rf_read1),
        .rf_read2      (rf_read2),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_addr      (rsp_addr),
        .rsp_last      (rsp_last),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Single write: one-cycle write strobe (none for x0), then idle again.
    task automatic do_write(input logic [4:0] a, input logic [XLEN-1:0] d);
        @(negedge clock);
        check("wr_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_count = 6'($urandom_range(63));
        @(negedge clock);
        cmd_valid = 1'b0;
        check("wr_strobe", rf_reg_write, (a != 5'd0));
        check("wr_busy", busy, 1);
        check("wr_cmd_ready_low", cmd_ready, 0);
        if (a != 5'd0) begin
            check("wr_reg", rf_write_reg, {1'b0, a});
            check("wr_data", rf_write_data, d);
        end
        @(negedge clock);
        check("wr_strobe_end", rf_reg_write, 0);
        check("wr_idle", cmd_ready, 1);
    endtask

    // Burst read. The expected word list is built from the register file
    // contents at issue time; ready_pct sets rsp_ready probability.
    // exp_cycles > 0 also checks acceptance-to-final-handshake latency.
    task automatic do_read(input logic [4:0] a, input logic [5:0] cnt,
                           input int ready_pct, input int exp_cycles);
        int              n;
        logic [4:0]      exp_addr [$];
        logic [XLEN-1:0] exp_data [$];
        int              got, idx, first_vld, done, fetches, n_fetch;
        logic            rdy, stalled;
        logic [XLEN-1:0] prev_data;
        logic [4:0]      prev_addr;
        logic            prev_last;

        n = (cnt > 6'd32) ? 32 : int'(cnt);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(5'(a + 5'(i)));
            exp_data.push_back(regs[5'(a + 5'(i))]);
        end
        n_fetch = (n + 1) / 2;

        @(negedge clock);
        check("rd_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_count = cnt;
        cmd_wdata = {$urandom, $urandom};
        rsp_ready = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;

        got = 0; idx = 1; first_vld = -1; done = -1; fetches = 0; stalled = 1'b0;
        prev_data = '0; prev_addr = '0; prev_last = 1'b0;
        while (got < n && idx < 400) begin
            if (busy && !rsp_valid) begin
                check("fetch_read1", rf_read1, {1'b0, 5'(a + 5'(2 * fetches))});
                check("fetch_read2", rf_read2, {1'b0, 5'(a + 5'(2 * fetches + 1))});
                fetches++;
            end
            if (stalled) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_data", rsp_data, prev_data);
                check("stall_addr", rsp_addr, prev_addr);
                check("stall_last", rsp_last, prev_last);
            end
            rdy = ($urandom_range(99) < ready_pct);
            rsp_ready = rdy;
            stalled = 1'b0;
            if (rsp_valid) begin
                if (first_vld < 0) first_vld = idx;
                if (rdy) begin
                    check("rsp_addr", rsp_addr, exp_addr[got]);
                    check("rsp_data", rsp_data, exp_data[got]);
                    check("rsp_last", rsp_last, (got == n - 1));
                    got++;
                    if (got == n) done = idx;
                end else begin
                    stalled   = 1'b1;
                    prev_data = rsp_data;
                    prev_addr = rsp_addr;
                    prev_last = rsp_last;
                end
            end
            @(negedge clock);
            idx++;
        end
        rsp_ready = 1'b0;

        check("rd_words", got, n);
        check("rd_fetches", fetches, n_fetch);
        if (n > 0) check("rd_first_valid_cycle", first_vld, 2);
        if (exp_cycles > 0) check("rd_latency", done, exp_cycles);
        check("rd_end_busy", busy, 0);
        check("rd_end_cmd_ready", cmd_ready, 1);
        // No extra or duplicated words after the burst.
        for (int k = 0; k < 3; k++) begin
            check("rd_no_extra", rsp_valid, 0);
            @(negedge clock);
        end
    endtask

    initial begin
        int viol;
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_count = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = '0;

        #12;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_last", rsp_last, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_addr", rsp_addr, 0);
        check("rst_reg_write", rf_reg_write, 0);
        check("rst_read1", rf_read1, 0);
        check("rst_read2", rf_read2, 0);
        check("rst_write_reg", rf_write_reg, 0);
        @(negedge clock);
        resetn = 1'b1;

        // Write then read back.
        do_write(5'd5, 64'hDEAD_BEEF_0000_0001);
        check("x5_in_rf", regs[5], 64'hDEAD_BEEF_0000_0001);
        do_read(5'd5, 6'd1, 100, 2);

        // Full dump with distinctive contents.
        for (int i = 0; i < NREG; i++) regs[i] = 64'(i * 'h11);
        do_read(5'd0, 6'd32, 100, 48);

        // Wrap and odd count.
        do_read(5'd30, 6'd3, 100, 0);

        // Backpressure, count 0, saturated count.
        for (int i = 1; i < NREG; i++) regs[i] = {$urandom, $urandom};
        do_read(5'($urandom_range(31)), 6'd7, 50, 0);
        do_read(5'd9, 6'd0, 100, 0);
        do_read(5'd17, 6'd40, 100, 48);

        // x0 is never written.
        do_write(5'd0, 64'hFF);
        check("x0_zero", regs[0], 0);

        // Randomized mix.
        for (int t = 0; t < 8; t++) begin
            do_write(5'($urandom_range(1, 31)), {$urandom, $urandom});
            do_read(5'($urandom_range(31)), 6'($urandom_range(63)), $urandom_range(30, 100), 0);
        end

        // Reset during SEND1 of a count-8 read.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'd10;
        cmd_count = 6'd8;
        rsp_ready = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        viol = 0;
        while (!(rsp_valid && rsp_addr == 5'd11) && viol < 50) begin
            @(negedge clock);
            viol++;
        end
        check("reach_send1", (viol < 50), 1);
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_data", rsp_data, 0);
        @(negedge clock);
        resetn = 1'b1;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid || busy) viol++;
        end
        check("no_resume_after_reset", viol, 0);
        rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_debug_port.md
# regfile_debug_port

Debug-side initiator for the 32 x 64-bit register file: accepts host commands over a valid/ready channel and drives the register file's two read ports and single write port on the host's behalf. Reads are burst transfers that fetch two consecutive registers per access and stream them back over a valid/ready response channel. Writes are single-register transfers. The block sits between the debug transport and the register file port mux, and asserts `busy` so the core can be held off while it owns the ports.

## Interface
- `XLEN`, default 64: register data width.
- `NREG`, default 32: number of architectural registers; register numbers wrap modulo `NREG`.
- `RAW`, default 6: width of the register-file address ports. Only bits [4:0] are significant; bit 5 is always driven 0.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_write`  in  1  1 = single write, 0 = burst read.
- `cmd_addr`  in  5  start register number.
- `cmd_count`  in  6  read burst length; 0 = no-op; values above 32 saturate to 32.
- `cmd_wdata`  in  XLEN  write data.
- `rf_read1`, `rf_read2`  out  RAW  register-file read addresses.
- `rf_data1`, `rf_data2`  in  XLEN  register-file read data; combinational from the addresses.
- `rf_write_reg`  out  RAW  write address.
- `rf_write_data`  out  XLEN  write data.
- `rf_reg_write`  out  1  write enable.
- `rsp_valid`  out  1  response word present.
- `rsp_ready`  in  1  host accepts the response word.
- `rsp_data`  out  XLEN  register value.
- `rsp_addr`  out  5  register number of `rsp_data`.
- `rsp_last`  out  1  final word of the burst.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, WRITE, FETCH, SEND0, SEND1.

IDLE
- `cmd_ready` = 1.
- On `cmd_valid && cmd_ready`, the block latches the address, data and count.
- Write command: go to WRITE.
- Read command with count 0: stay in IDLE; no response is produced.
- Read command with count 1..32: go to FETCH, with `remaining` = saturated count.

WRITE (one cycle)
- Drives `rf_write_reg` = addr, `rf_write_data` = wdata, and `rf_reg_write` = 1.
- Exception: when addr = 0, `rf_reg_write` stays 0 (x0 is hardwired zero).
- Next state: IDLE.

FETCH (one cycle)
- Drives `rf_read1` = addr and `rf_read2` = (addr+1) mod 32.
- At the clock edge, captures `rf_data1` into buf0 and `rf_data2` into buf1.
- Next state: SEND0.

SEND0
- Drives `rsp_valid` = 1, `rsp_data` = buf0, `rsp_addr` = addr.
- `rsp_last` = (remaining == 1).
- On `rsp_ready`:
  - remaining == 1: go to IDLE.
  - otherwise: go to SEND1.

SEND1
- Drives `rsp_valid` = 1, `rsp_data` = buf1, `rsp_addr` = (addr+1) mod 32.
- `rsp_last` = (remaining == 2).
- On `rsp_ready`:
  - remaining is decremented by 2 and addr is advanced by 2, modulo 32.
  - If remaining was 2: go to IDLE; otherwise go to FETCH.

General rules
- While `rsp_valid` is high and `rsp_ready` is low, `rsp_data`, `rsp_addr` and `rsp_last` hold stable.
- `remaining` is a 6-bit counter and never underflows.
- Address arithmetic is 5-bit and wraps from 31 to 0.
- Returned values are a snapshot taken at the FETCH edge. Writes by the core after that edge are not reflected in the response.

## Timing
- Reset (async assert) values:
  - state = IDLE, `cmd_ready` = 1, `busy` = 0.
  - `rsp_valid` = 0, `rsp_last` = 0, `rsp_data` = 0, `rsp_addr` = 0.
  - `rf_reg_write` = 0, all `rf_*` addresses and data = 0, buf0 = buf1 = 0.
- Reset mid-operation aborts immediately:
  - `rsp_valid` and `rf_reg_write` drop asynchronously.
  - No partial burst resumes after reset deasserts.
- Write latency: accepted at edge E0; `rf_reg_write` is high for exactly the cycle between E0 and E1; `cmd_ready` is back to 1 after E1.
- Read latency: accepted at E0; FETCH occupies E0..E1; the first `rsp_valid` is visible after E1.
- Read throughput with `rsp_ready` held at 1: 2 words every 3 cycles. A 32-register dump completes 48 cycles after acceptance.
- `cmd_ready` is 0 in every non-IDLE state, so no command is accepted mid-burst.
- `busy` is registered state decode; there is no combinational path from `cmd_valid`.

## Test plan
- Write then read:
  - Write x5 = 0xDEAD_BEEF_0000_0001.
  - Read count 1 at addr 5.
  - Required: `rf_reg_write` pulses for 1 cycle with reg 5; then a single response, `rsp_addr` = 5, data matches, `rsp_last` = 1.
- Full dump:
  - Preload reg i = i*0x11.
  - Read count 32 from addr 0 with `rsp_ready` = 1.
  - Required: 32 responses, addrs 0..31 in order, `rsp_last` only on addr 31, completion 48 cycles after accept.
- Wrap and odd count:
  - Read count 3 from addr 30.
  - Required: addrs 30, 31, 0, in that order; `rsp_last` on the third; `rf_read2` = 31, then 1.
- Backpressure and edge cases:
  - Random `rsp_ready` toggling during a count-7 read: data stable while stalled, no loss or duplication.
  - Count 0: no `rsp_valid`, `cmd_ready` stays 1.
  - Count 40: exactly 32 words.
- x0 and reset:
  - Write x0 = 0xFF: `rf_reg_write` stays 0.
  - Assert `resetn` low during SEND1 of a count-8 read: `rsp_valid` = 0 immediately, state IDLE, no further responses after release.
